// File: rtl/haze_pkg.sv
// ============================================================================
// Module      : haze_pkg
// Description : Shared pixel types, frame geometry and helpers for the haze
//               streaming pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package haze_pkg;

    localparam int DATA_W     = 24;
    localparam int IMG_WIDTH  = 512;
    localparam int IMG_HEIGHT = 512;

    typedef logic [23:0] pixel_t;

    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    typedef pixel_t [8:0] window_t;

    // Index width for a counter or address spanning n entries.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/window_3x3_gen_if.sv
// ============================================================================
// Module      : window_3x3_gen_if
// Description : Pixel stream in, 3x3 window plus centre coordinates out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface window_3x3_gen_if #(
    parameter int IMG_WIDTH  = haze_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = haze_pkg::IMG_HEIGHT,
    parameter int DATA_W     = haze_pkg::DATA_W
);
    import haze_pkg::*;

    localparam int c_xw = idx_w(IMG_WIDTH);
    localparam int c_yw = idx_w(IMG_HEIGHT);

    logic              in_valid;
    logic [DATA_W-1:0] in_pixel;
    logic              out_valid;
    logic [DATA_W-1:0] pixel_1, pixel_2, pixel_3;
    logic [DATA_W-1:0] pixel_4, pixel_5, pixel_6;
    logic [DATA_W-1:0] pixel_7, pixel_8, pixel_9;
    logic [c_xw-1:0]   out_x;
    logic [c_yw-1:0]   out_y;
    logic              frame_done;

    modport master (
        output in_valid, in_pixel,
        input  out_valid, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5,
               pixel_6, pixel_7, pixel_8, pixel_9, out_x, out_y, frame_done
    );

    modport slave (
        input  in_valid, in_pixel,
        output out_valid, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5,
               pixel_6, pixel_7, pixel_8, pixel_9, out_x, out_y, frame_done
    );

endinterface

`default_nettype wire

// File: rtl/window_3x3_gen_line_buffer.sv
// ============================================================================
// Module      : line_buffer
// Description : Single-port read-first RAM holding one image row.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buffer
    import haze_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic                     i_we,
    input  logic [idx_w(DEPTH)-1:0]  i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register samples the pre-write contents of the addressed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/window_3x3_gen.sv
// ============================================================================
// Module      : window_3x3_gen
// Description : Streaming 3x3 window generator with two row buffers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module window_3x3_gen #(
    parameter int IMG_WIDTH  = haze_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = haze_pkg::IMG_HEIGHT,
    parameter int DATA_W     = haze_pkg::DATA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    window_3x3_gen_if.slave bus
);
    import haze_pkg::*;

    localparam int              c_xw     = idx_w(IMG_WIDTH);
    localparam int              c_yw     = idx_w(IMG_HEIGHT);
    localparam logic [c_xw-1:0] c_x_last = c_xw'(IMG_WIDTH - 1);
    localparam logic [c_yw-1:0] c_y_last = c_yw'(IMG_HEIGHT - 1);

    logic              w_accept, w_x_last, w_y_last, w_emit;
    logic [c_xw-1:0]   r_x, r_out_x;
    logic [c_yw-1:0]   r_y, r_out_y;
    logic              r_par, r_out_valid, r_frame_done;
    logic [DATA_W-1:0] r_pix;
    logic [DATA_W-1:0] w_rd    [2];
    logic [DATA_W-1:0] r_col_l [3];
    logic [DATA_W-1:0] r_col_m [3];
    logic [DATA_W-1:0] w_col_r [3];
    logic [DATA_W-1:0] w_live  [9];
    logic [DATA_W-1:0] r_hold  [9];
    logic [DATA_W-1:0] w_win   [9];

    assign w_accept = bus.in_valid;
    assign w_x_last = (r_x == c_x_last);
    assign w_y_last = (r_y == c_y_last);
    assign w_emit   = (r_x >= c_xw'(2)) && (r_y >= c_yw'(2));

    // Rows alternate between the two buffers: the one holding row y-2 is
    // read and overwritten with row y in the same read-first access.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_lb
            line_buffer #(
                .DEPTH (IMG_WIDTH),
                .WIDTH (DATA_W)
            ) u_lb (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_en    (w_accept),
                .i_we    (w_accept && (int'(r_y[0]) == g)),
                .i_addr  (r_x),
                .i_wdata (bus.in_pixel),
                .o_rdata (w_rd[g])
            );
        end
    endgenerate

    always_comb begin
        w_col_r[0] = r_par ? w_rd[1] : w_rd[0];
        w_col_r[1] = r_par ? w_rd[0] : w_rd[1];
        w_col_r[2] = r_pix;
        for (int r = 0; r < 3; r++) begin
            w_live[3*r]     = r_col_l[r];
            w_live[3*r + 1] = r_col_m[r];
            w_live[3*r + 2] = w_col_r[r];
        end
        // Between emissions the last emitted window stays on the outputs.
        for (int k = 0; k < 9; k++) begin
            w_win[k] = r_out_valid ? w_live[k] : r_hold[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_par        <= 1'b0;
            r_pix        <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                r_col_l[r] <= '0;
                r_col_m[r] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                r_hold[k] <= '0;
            end
        end else begin
            r_out_valid  <= w_accept && w_emit;
            r_frame_done <= w_accept && w_x_last && w_y_last;
            if (r_out_valid) begin
                for (int k = 0; k < 9; k++) begin
                    r_hold[k] <= w_live[k];
                end
            end
            if (w_accept) begin
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + c_yw'(1);
                end else begin
                    r_x <= r_x + c_xw'(1);
                end
                r_par <= r_y[0];
                r_pix <= bus.in_pixel;
                for (int r = 0; r < 3; r++) begin
                    r_col_l[r] <= r_col_m[r];
                    r_col_m[r] <= w_col_r[r];
                end
                if (w_emit) begin
                    r_out_x <= r_x - c_xw'(1);
                    r_out_y <= r_y - c_yw'(1);
                end
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.out_x      = r_out_x;
    assign bus.out_y      = r_out_y;
    assign bus.pixel_1    = w_win[0];
    assign bus.pixel_2    = w_win[1];
    assign bus.pixel_3    = w_win[2];
    assign bus.pixel_4    = w_win[3];
    assign bus.pixel_5    = w_win[4];
    assign bus.pixel_6    = w_win[5];
    assign bus.pixel_7    = w_win[6];
    assign bus.pixel_8    = w_win[7];
    assign bus.pixel_9    = w_win[8];

endmodule

`default_nettype wire

// File: tb/tb_window_3x3_gen.sv
// ============================================================================
// Module      : tb_window_3x3_gen
// Description : Self-checking bench: a 4x4 instance and a 5x5 instance
//               checked against an image-array window model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_window_3x3_gen;

    localparam int W0 = 4, H0 = 4, W1 = 5, H1 = 5;

    typedef struct packed {
        int               x;
        int               y;
        logic [8:0][23:0] win;
    } exp_t;

    typedef struct {
        logic [23:0] pix;
        bit          ev;
        int          ox, oy;
        logic [23:0] p1, p5, p9;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    window_3x3_gen_if #(.IMG_WIDTH(W0), .IMG_HEIGHT(H0), .DATA_W(24)) if0 ();
    window_3x3_gen_if #(.IMG_WIDTH(W1), .IMG_HEIGHT(H1), .DATA_W(24)) if1 ();

    window_3x3_gen #(.IMG_WIDTH(W0), .IMG_HEIGHT(H0), .DATA_W(24)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    window_3x3_gen #(.IMG_WIDTH(W1), .IMG_HEIGHT(H1), .DATA_W(24)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    always #5 clk = ~clk;

    exp_t        q0[$], q1[$];
    logic [23:0] img [2][5][5];
    int          mx[2], my[2];
    bit          pend_v[2], pend_fd[2], ev[2], efd[2];
    int          n_pass = 0, n_total = 0;
    int          n_emit[2], n_fd[2];
    int          rowcnt[5];
    vec_t        tbl[16];

    function automatic int wid(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic int hgt(input int d);
        return (d == 0) ? H0 : H1;
    endfunction

    function automatic logic [23:0] pv(input int x, input int y, input int off);
        logic [7:0] b;
        b = 8'(16 * y + x + off);
        return {b, b, b};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: full image of the current frame, windows read straight from it.
    task automatic accept(input int d, input logic [23:0] pix);
        int   x, y;
        exp_t e;
        x = mx[d];
        y = my[d];
        img[d][y][x] = pix;
        if (x >= 2 && y >= 2) begin
            e.x   = x - 1;
            e.y   = y - 1;
            e.win = {img[d][y-2][x-2], img[d][y-2][x-1], img[d][y-2][x],
                     img[d][y-1][x-2], img[d][y-1][x-1], img[d][y-1][x],
                     img[d][y][x-2],   img[d][y][x-1],   img[d][y][x]};
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            pend_v[d] = 1'b1;
        end
        pend_fd[d] = (x == wid(d) - 1) && (y == hgt(d) - 1);
        if (x == wid(d) - 1) begin
            mx[d] = 0;
            my[d] = (y == hgt(d) - 1) ? 0 : y + 1;
        end else begin
            mx[d] = x + 1;
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the next one.
    task automatic step(input int d, input bit v, input logic [23:0] pix);
        if0.in_valid = (d == 0) && v;
        if0.in_pixel = pix;
        if1.in_valid = (d == 1) && v;
        if1.in_pixel = pix;
        pend_v  = '{1'b0, 1'b0};
        pend_fd = '{1'b0, 1'b0};
        if (v) accept(d, pix);
        @(posedge clk);
        #1;
    endtask

    task automatic mon(input int d, input bit ov, input bit fd, input int ox, input int oy,
                       input logic [215:0] w);
        exp_t e;
        check($sformatf("out_valid%0d", d), 256'(ov), 256'(ev[d]));
        check($sformatf("frame_done%0d", d), 256'(fd), 256'(efd[d]));
        if (fd) n_fd[d]++;
        if (ov) begin
            n_emit[d]++;
            if (d == 1 && oy >= 0 && oy < 5) rowcnt[oy]++;
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                n_total++;
                $display("FAIL sb_empty%0d: got window at (%0d,%0d) expected none", d, ox, oy);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("centre%0d", d), {ox, oy}, {e.x, e.y});
                check($sformatf("window%0d", d), 256'(w), 256'(e.win));
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev  <= '{1'b0, 1'b0};
            efd <= '{1'b0, 1'b0};
        end else begin
            ev  <= pend_v;
            efd <= pend_fd;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, if0.out_valid, if0.frame_done, int'(if0.out_x), int'(if0.out_y),
                {if0.pixel_1, if0.pixel_2, if0.pixel_3, if0.pixel_4, if0.pixel_5,
                 if0.pixel_6, if0.pixel_7, if0.pixel_8, if0.pixel_9});
            mon(1, if1.out_valid, if1.frame_done, int'(if1.out_x), int'(if1.out_y),
                {if1.pixel_1, if1.pixel_2, if1.pixel_3, if1.pixel_4, if1.pixel_5,
                 if1.pixel_6, if1.pixel_7, if1.pixel_8, if1.pixel_9});
        end
    end

    task automatic check_zero0(input string name);
        check(name, 256'({if0.out_valid, if0.frame_done, if0.out_x, if0.out_y,
                          if0.pixel_1, if0.pixel_2, if0.pixel_3, if0.pixel_4, if0.pixel_5,
                          if0.pixel_6, if0.pixel_7, if0.pixel_8, if0.pixel_9}), 256'(0));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].pix = pv(i % 4, i / 4, 0);
            tbl[i].ev  = (i % 4 >= 2) && (i / 4 >= 2);
            tbl[i].ox  = i % 4 - 1;
            tbl[i].oy  = i / 4 - 1;
            tbl[i].p1  = pv(i % 4 - 2, i / 4 - 2, 0);
            tbl[i].p5  = pv(i % 4 - 1, i / 4 - 1, 0);
            tbl[i].p9  = pv(i % 4, i / 4, 0);
        end
        mx = '{0, 0}; my = '{0, 0};
        n_emit = '{0, 0}; n_fd = '{0, 0};
        rowcnt = '{0, 0, 0, 0, 0};
        pend_v = '{1'b0, 1'b0}; pend_fd = '{1'b0, 1'b0};
        if0.in_valid = 1'b0; if0.in_pixel = '0;
        if1.in_valid = 1'b0; if1.in_pixel = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero0("reset_out0");
        check("reset_out1", 256'({if1.out_valid, if1.frame_done, if1.out_x, if1.out_y,
                                  if1.pixel_1, if1.pixel_5, if1.pixel_9}), 256'(0));
        rst_n = 1'b1;
        step(0, 1'b0, '0);

        // 4x4 frame, continuous valid, table-driven
        for (int i = 0; i < 16; i++) begin
            step(0, 1'b1, tbl[i].pix);
            check($sformatf("tbl_valid[%0d]", i), 256'(if0.out_valid), 256'(tbl[i].ev));
            if (tbl[i].ev) begin
                check($sformatf("tbl_xy[%0d]", i), {int'(if0.out_x), int'(if0.out_y)},
                      {tbl[i].ox, tbl[i].oy});
                check($sformatf("tbl_p1[%0d]", i), 256'(if0.pixel_1), 256'(tbl[i].p1));
                check($sformatf("tbl_p5[%0d]", i), 256'(if0.pixel_5), 256'(tbl[i].p5));
                check($sformatf("tbl_p9[%0d]", i), 256'(if0.pixel_9), 256'(tbl[i].p9));
            end
            if (i == 10) begin
                check("first_p1", 256'(if0.pixel_1), 256'(24'h000000));
                check("first_p5", 256'(if0.pixel_5), 256'(24'h111111));
                check("first_p9", 256'(if0.pixel_9), 256'(24'h222222));
            end
        end
        step(0, 1'b0, '0);
        check("emits_contig", 256'(n_emit[0]), 256'(4));

        // Same frame with alternating gaps
        n_emit[0] = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 1'b1, pv(i % 4, i / 4, 0));
            step(0, 1'b0, '0);
        end
        check("emits_gapped", 256'(n_emit[0]), 256'(4));

        // Two back-to-back frames, the second offset by 0x80
        n_emit[0] = 0; n_fd[0] = 0;
        for (int i = 0; i < 32; i++) begin
            step(0, 1'b1, pv(i % 4, (i / 4) % 4, (i >= 16) ? 8'h80 : 0));
            if (i == 26) begin
                check("f2_centre", {int'(if0.out_x), int'(if0.out_y)}, {32'd1, 32'd1});
                check("f2_p1", 256'(if0.pixel_1), 256'(24'h808080));
            end
        end
        step(0, 1'b0, '0);
        check("emits_b2b", 256'(n_emit[0]), 256'(8));
        check("frame_done_b2b", 256'(n_fd[0]), 256'(2));

        // Reset after 7 pixels, then a fresh frame
        for (int i = 0; i < 7; i++) step(0, 1'b1, pv(i % 4, i / 4, 8'h40));
        check("q_before_rst", 256'(q0.size()), 256'(0));
        rst_n = 1'b0;
        #2;
        check_zero0("midframe_reset");
        @(posedge clk);
        #1;
        check_zero0("reset_held");
        mx = '{0, 0}; my = '{0, 0};
        rst_n = 1'b1;
        step(0, 1'b0, '0);
        n_emit[0] = 0;
        for (int i = 0; i < 16; i++) step(0, 1'b1, pv(i % 4, i / 4, 8'h20));
        step(0, 1'b0, '0);
        check("emits_after_rst", 256'(n_emit[0]), 256'(4));
        check("q0_drained", 256'(q0.size()), 256'(0));

        // 5x5 random frames with random gaps: row wrap and per-row counts
        n_emit[1] = 0; n_fd[1] = 0;
        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(3) == 0) step(1, 1'b0, '0);
            step(1, 1'b1, 24'($urandom));
        end
        step(1, 1'b0, '0);
        check("emits_5x5", 256'(n_emit[1]), 256'(18));
        check("frame_done_5x5", 256'(n_fd[1]), 256'(2));
        for (int r = 1; r <= 3; r++) check($sformatf("row_count[%0d]", r), 256'(rowcnt[r]), 256'(6));
        check("q1_drained", 256'(q1.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
